// File: rtl/heptagon_area_sched.sv
`default_nettype none
// ============================================================================
// Module   : heptagon_area_sched
// Purpose  : Frame controller that loads polygon points, time-shares one area
//            unit across the polygons, insertion-sorts the areas and streams
//            (Index, Area) pairs in ascending-area order.
// Revision : 1.0 - initial release
// ============================================================================
module heptagon_area_sched #(
    parameter int NPOLY    = 5,
    parameter int NVERT    = 7,
    parameter int AW       = 19,
    parameter int IW       = 3,
    parameter int PW       = 6,
    parameter int MAX_WAIT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          pt_wr_en,
    output logic [PW-1:0] pt_wr_addr,
    output logic          calc_start,
    output logic [IW-1:0] calc_poly,
    input  logic          calc_done,
    input  logic [AW-1:0] calc_area,
    output logic          valid,
    output logic [IW-1:0] Index,
    output logic [AW-1:0] Area,
    output logic          busy,
    output logic          err
);

    localparam int            WW        = $clog2(MAX_WAIT + 1);
    localparam logic [PW-1:0] c_LAST_PT = PW'(NPOLY * NVERT - 1);
    localparam logic [IW-1:0] c_LAST_IX = IW'(NPOLY - 1);
    localparam logic [WW-1:0] c_LAST_WT = WW'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_INSERT = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_pt_cnt;
    logic [IW-1:0] r_k;
    logic [IW-1:0] r_rank;
    logic [WW-1:0] r_wait_cnt;
    logic [AW-1:0] r_new_area;
    logic          r_err;
    logic [AW-1:0] r_list_area [NPOLY];
    logic [IW-1:0] r_list_idx  [NPOLY];
    logic [AW-1:0] r_hold_area;
    logic [IW-1:0] r_hold_idx;

    logic          w_accept;
    logic          w_last_pt;
    logic          w_timeout;
    logic          w_last_poly;
    logic          w_last_rank;
    logic [NPOLY-1:0] w_le;
    logic [AW-1:0] w_ins_area [NPOLY];
    logic [IW-1:0] w_ins_idx  [NPOLY];

    assign w_accept    = in_valid && (r_state == S_LOAD);
    assign w_last_pt   = (r_pt_cnt == c_LAST_PT);
    assign w_timeout   = (r_wait_cnt == c_LAST_WT);
    assign w_last_poly = (r_k == c_LAST_IX);
    assign w_last_rank = (r_rank == c_LAST_IX);

    // Entries already in the list with area <= new stay put (stable on ties);
    // the list is sorted, so w_le is a prefix mask and the new entry lands at
    // its first zero while everything after it shifts up by one.
    always_comb begin
        for (int j = 0; j < NPOLY; j++) begin
            w_le[j] = (IW'(j) < r_k) && (r_list_area[j] <= r_new_area);
        end
        w_ins_area[0] = w_le[0] ? r_list_area[0] : r_new_area;
        w_ins_idx[0]  = w_le[0] ? r_list_idx[0]  : r_k;
        for (int j = 1; j < NPOLY; j++) begin
            if (w_le[j]) begin
                w_ins_area[j] = r_list_area[j];
                w_ins_idx[j]  = r_list_idx[j];
            end else if (w_le[j-1]) begin
                w_ins_area[j] = r_new_area;
                w_ins_idx[j]  = r_k;
            end else begin
                w_ins_area[j] = r_list_area[j-1];
                w_ins_idx[j]  = r_list_idx[j-1];
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        calc_start = 1'b0;
        valid      = 1'b0;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (w_accept && w_last_pt) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                calc_start = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (calc_done || w_timeout) w_next = S_INSERT;
            end
            S_INSERT: begin
                w_next = w_last_poly ? S_OUT : S_ISSUE;
            end
            S_OUT: begin
                valid = 1'b1;
                if (w_last_rank) w_next = S_LOAD;
            end
            default: w_next = S_LOAD;
        endcase
    end

    assign pt_wr_en   = in_valid && in_ready;
    assign pt_wr_addr = r_pt_cnt;
    assign calc_poly  = r_k;
    assign busy       = (r_state != S_LOAD);
    assign err        = r_err;

    always_comb begin
        Index = r_hold_idx;
        Area  = r_hold_area;
        if (r_state == S_OUT) begin
            Index = r_list_idx[r_rank];
            Area  = r_list_area[r_rank];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_LOAD;
            r_pt_cnt    <= '0;
            r_k         <= '0;
            r_rank      <= '0;
            r_wait_cnt  <= '0;
            r_new_area  <= '0;
            r_err       <= 1'b0;
            r_hold_area <= '0;
            r_hold_idx  <= '0;
            for (int j = 0; j < NPOLY; j++) begin
                r_list_area[j] <= '0;
                r_list_idx[j]  <= '0;
            end
        end else begin
            r_state <= w_next;
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        r_pt_cnt <= w_last_pt ? '0 : r_pt_cnt + 1'b1;
                        if (r_pt_cnt == '0) r_err <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= '0;
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (calc_done) begin
                        r_new_area <= calc_area;
                    end else if (w_timeout) begin
                        r_new_area <= '0;
                        r_err      <= 1'b1;
                    end
                end
                S_INSERT: begin
                    for (int j = 0; j < NPOLY; j++) begin
                        r_list_area[j] <= w_ins_area[j];
                        r_list_idx[j]  <= w_ins_idx[j];
                    end
                    if (!w_last_poly) r_k <= r_k + 1'b1;
                end
                S_OUT: begin
                    r_hold_area <= r_list_area[r_rank];
                    r_hold_idx  <= r_list_idx[r_rank];
                    if (w_last_rank) begin
                        r_rank <= '0;
                        r_k    <= '0;
                    end else begin
                        r_rank <= r_rank + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
